// File: rtl/spi_master_periph_if.sv
// Purpose : PicoRV32 native memory bus bundle for the SPI master peripheral.
//           The address-decoder select (enable) is carried here too, so the
//           whole request/acknowledge path is one connection.
// Signals : enable     address-decoder select for this block
//           mem_valid  request valid
//           mem_instr  instruction fetch flag (ignored by the peripheral)
//           mem_wstrb  byte write strobes, 0000 = read
//           mem_wdata  write data
//           mem_addr   byte address, [3:2] picks the register
//           mem_ready  single-cycle acknowledge from the peripheral
//           mem_rdata  read data, zero whenever mem_ready is low
interface spi_master_periph_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/spi_master_periph.sv
// Purpose : SPI master (mode 0, MSB first, 8-bit) on the PicoRV32 bus.
//           Writing DATA starts a transfer. The byte captured from MISO
//           lands in rx_data. Chip select follows CTRL[0] in software only.
// Ports   : i_clk        system clock
//           i_reset      asynchronous reset, active-high
//           bus          memory bus, slave side (see spi_master_periph_if)
//           o_spi_sclk   SPI clock, idles low
//           o_spi_mosi   master out
//           i_spi_miso   master in, sampled on rising SCLK
//           o_spi_cs_n   chip select, active-low, ~CTRL[0]
// Registers (mem_addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
//
// state | meaning
// IDLE  | no transfer; DATA writes are accepted
// XFER  | shifting; SCLK toggles every DIV+1 clocks, 16 edges total
// DONE  | one cycle: publish rx byte, set rx_valid, park MOSI low
module spi_master_periph #(
    parameter logic [15:0] DEFAULT_DIV = 16'd49
) (
    input  logic               i_clk,
    input  logic               i_reset,
    spi_master_periph_if.slave bus,
    output logic               o_spi_sclk,
    output logic               o_spi_mosi,
    input  logic               i_spi_miso,
    output logic               o_spi_cs_n
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_en;
    logic [15:0] r_div;
    logic [15:0] r_div_cnt;
    logic [4:0]  r_edge_cnt;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;

    logic [1:0]  w_sel;
    logic        w_is_rd;
    logic        w_is_data_wr;
    logic        w_accept;
    logic        w_start;
    logic        w_tick;
    logic        w_busy;
    logic [31:0] w_rdata_nxt;

    assign w_sel        = bus.mem_addr[3:2];
    assign w_is_rd      = (bus.mem_wstrb == 4'b0000);
    assign w_is_data_wr = (w_sel == 2'd0) && !w_is_rd;
    assign w_busy       = (r_state != IDLE);
    // A DATA write while shifting is held off until the FSM is back in IDLE.
    assign w_accept     = bus.mem_valid && bus.enable && !r_ready &&
                          !(w_is_data_wr && w_busy);
    assign w_start      = w_accept && w_is_data_wr && bus.mem_wstrb[0];
    assign w_tick       = (r_state == XFER) && (r_div_cnt == r_div);

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = r_rdata;
    assign o_spi_sclk    = r_sclk;
    assign o_spi_mosi    = r_mosi;
    assign o_spi_cs_n    = ~r_cs_en;

    wire w_unused = &{1'b0, bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0],
                      bus.mem_wdata[31:16], bus.mem_wstrb[3:2]};

    always_comb begin
        w_rdata_nxt = 32'h0;
        if (w_accept && w_is_rd) begin
            case (w_sel)
                2'd0:    w_rdata_nxt = {24'h0, r_rx_data};
                2'd1:    w_rdata_nxt = {30'h0, r_rx_valid, w_busy};
                2'd2:    w_rdata_nxt = {31'h0, r_cs_en};
                default: w_rdata_nxt = {16'h0, r_div};
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = XFER;
            XFER:    if (w_tick && (r_edge_cnt == 5'd15)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_en    <= 1'b0;
            r_div      <= DEFAULT_DIV;
            r_div_cnt  <= 16'h0;
            r_edge_cnt <= 5'h0;
            r_tx_shift <= 8'h0;
            r_rx_shift <= 8'h0;
            r_rx_data  <= 8'h0;
            r_rx_valid <= 1'b0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_rdata_nxt;

            if (w_accept && !w_is_rd && bus.mem_wstrb[0]) begin
                if (w_sel == 2'd2) r_cs_en    <= bus.mem_wdata[0];
                if (w_sel == 2'd3) r_div[7:0] <= bus.mem_wdata[7:0];
            end
            if (w_accept && !w_is_rd && bus.mem_wstrb[1] && (w_sel == 2'd3))
                r_div[15:8] <= bus.mem_wdata[15:8];

            if (w_accept && w_is_rd && (w_sel == 2'd0))
                r_rx_valid <= 1'b0;

            if (w_start) begin
                r_tx_shift <= bus.mem_wdata[7:0];
                r_mosi     <= bus.mem_wdata[7];
                r_div_cnt  <= 16'h0;
                r_edge_cnt <= 5'h0;
            end

            if (r_state == XFER) begin
                if (w_tick) begin
                    r_div_cnt  <= 16'h0;
                    r_sclk     <= ~r_sclk;
                    r_edge_cnt <= r_edge_cnt + 5'd1;
                    if (!r_sclk) begin
                        r_rx_shift <= {r_rx_shift[6:0], i_spi_miso};
                    end else if (r_edge_cnt != 5'd15) begin
                        // Mode 0: the next bit goes out on the falling edge.
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        r_mosi     <= r_tx_shift[6];
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 16'd1;
                end
            end

            // Placed after the read-clear so a same-cycle set takes priority.
            if (r_state == DONE) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_mosi     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_periph.sv
module tb_spi_master_periph;
    localparam logic [31:0] A_DATA   = 32'h0200_0000;
    localparam logic [31:0] A_STATUS = 32'h0200_0004;
    localparam logic [31:0] A_CTRL   = 32'h0200_0008;
    localparam logic [31:0] A_DIV    = 32'h0200_000C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk, mosi, cs_n;
    logic miso;
    logic miso_one = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_ack0, t_ack1, t_dummy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = miso_one ? 1'b1 : mosi;

    spi_master_periph_if bus();

    spi_master_periph dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .bus        (bus.slave),
        .o_spi_sclk (sclk),
        .o_spi_mosi (mosi),
        .i_spi_miso (miso),
        .o_spi_cs_n (cs_n)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
        string       tag;
    } bus_exp_t;

    typedef struct {
        logic mosi;
        logic cs_n;
        int   period;
    } bit_exp_t;

    bus_exp_t bus_q[$];
    bit_exp_t bit_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus scoreboard: every acknowledge pops one expectation.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        bus_exp_t e;
        if (!rst && bus.mem_ready) begin
            check_val("ack_single", {31'h0, prev_ready}, 32'h0);
            if (bus_q.size() == 0) begin
                check_val("unexpected_ack", {31'h0, bus.mem_ready}, 32'h0);
            end else begin
                e = bus_q.pop_front();
                if (e.chk) check_val(e.tag, bus.mem_rdata, e.data);
            end
        end
        prev_ready <= bus.mem_ready;
    end

    // SPI scoreboard: each rising SCLK pops one expected MOSI bit.
    logic prev_sclk = 1'b0;
    int   since = 0;
    always @(negedge clk) begin
        bit_exp_t e;
        since++;
        if (!prev_sclk && sclk) begin
            if (bit_q.size() > 0) begin
                e = bit_q.pop_front();
                check_val("mosi_bit", {31'h0, mosi}, {31'h0, e.mosi});
                check_val("cs_n_xfer", {31'h0, cs_n}, {31'h0, e.cs_n});
                if (e.period > 0) check_val("sclk_period", since, e.period);
            end
            since = 0;
        end
        prev_sclk = sclk;
    end

    task automatic push_byte(input logic [7:0] b, input int period, input logic csn);
        for (int i = 7; i >= 0; i--)
            bit_q.push_back('{b[i], csn, (i == 7) ? 0 : period});
    endtask

    task automatic bus_req(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic [31:0] exp,
                           input bit chk, input string tag, output int ack_cyc);
        bus_q.push_back('{exp, chk, tag});
        @(posedge clk); #1;
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
        ack_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check_val({tag, "_timeout"}, {31'h0, bus.mem_ready}, 32'h1);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        int t;
        bus_req(addr, wstrb, wdata, 32'h0, 1'b0, "write", t);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int t;
        bus_req(addr, 4'h0, 32'h0, exp, 1'b1, tag, t);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0; bus.mem_valid = 1'b0; bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'h0; bus.mem_wdata = 32'h0; bus.mem_addr = 32'h0;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_sclk",  {31'h0, sclk}, 32'h0);
        check_val("rst_mosi",  {31'h0, mosi}, 32'h0);
        check_val("rst_cs_n",  {31'h0, cs_n}, 32'h1);
        check_val("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        check_val("rst_rdata", bus.mem_rdata, 32'h0);
        @(negedge clk) rst = 1'b0;

        // T1: reset in the middle of a transfer (DIV at reset value 49)
        wr(A_CTRL, 4'h1, 32'h1);
        wr(A_DATA, 4'h1, 32'hFF);
        repeat (70) @(negedge clk);
        check_val("t1_pre_sclk", {31'h0, sclk}, 32'h1);
        check_val("t1_pre_mosi", {31'h0, mosi}, 32'h1);
        check_val("t1_pre_cs_n", {31'h0, cs_n}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_val("t1_sclk",  {31'h0, sclk}, 32'h0);
        check_val("t1_mosi",  {31'h0, mosi}, 32'h0);
        check_val("t1_cs_n",  {31'h0, cs_n}, 32'h1);
        check_val("t1_ready", {31'h0, bus.mem_ready}, 32'h0);
        @(negedge clk) rst = 1'b0;
        rd(A_STATUS, 32'h0, "t1_status");
        rd(A_DIV, 32'h31, "t1_div");
        rd(A_CTRL, 32'h0, "t1_ctrl");
        rd(A_DATA, 32'h0, "t1_rxdata");

        // T5: bus isolation, then a STATUS write that must not change anything
        @(posedge clk); #1;
        bus.enable = 1'b0; bus.mem_valid = 1'b1; bus.mem_addr = A_STATUS; bus.mem_wstrb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("t5_ready", {31'h0, bus.mem_ready}, 32'h0);
            check_val("t5_rdata", bus.mem_rdata, 32'h0);
        end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        wr(A_STATUS, 4'hF, 32'hFFFF_FFFF);
        rd(A_STATUS, 32'h0, "t5_status");

        // Strobes: only byte 0 of DIV written; DATA write without wstrb[0] starts nothing
        wr(A_DIV, 4'h1, 32'hABCD_EF01);
        rd(A_DIV, 32'h0000_0001, "div_strobe");
        wr(A_DATA, 4'h2, 32'h0000_5500);
        rd(A_STATUS, 32'h0, "data_nostrobe");

        // T2: loopback, DIV=1
        wr(A_CTRL, 4'h1, 32'h1);
        check_val("t2_cs_n", {31'h0, cs_n}, 32'h0);
        push_byte(8'hA5, 4, 1'b0);
        wr(A_DATA, 4'h1, 32'hA5);
        repeat (40) @(posedge clk);
        rd(A_STATUS, 32'h2, "t2_status_valid");
        rd(A_DATA, 32'hA5, "t2_rxdata");
        rd(A_STATUS, 32'h0, "t2_status_clr");

        // T4: stalled DATA write, acked one cycle after the first transfer ends
        push_byte(8'h5A, 4, 1'b0);
        push_byte(8'h12, 4, 1'b0);
        bus_req(A_DATA, 4'h1, 32'h5A, 32'h0, 1'b0, "t4_wr0", t_ack0);
        bus_req(A_DATA, 4'h1, 32'h12, 32'h0, 1'b0, "t4_wr1", t_ack1);
        check_val("t4_stall_gap", t_ack1 - t_ack0, 16 * 2 + 2);
        repeat (40) @(posedge clk);
        rd(A_DATA, 32'h12, "t4_overrun_rx");
        rd(A_STATUS, 32'h0, "t4_status");

        // T3: MISO tied high, DIV=0, CS released
        wr(A_CTRL, 4'h1, 32'h0);
        check_val("t3_cs_n", {31'h0, cs_n}, 32'h1);
        miso_one = 1'b1;
        wr(A_DIV, 4'h3, 32'h0);
        rd(A_DIV, 32'h0, "t3_div");
        push_byte(8'h3C, 2, 1'b1);
        wr(A_DATA, 4'h1, 32'h3C);
        repeat (25) @(posedge clk);
        rd(A_DATA, 32'hFF, "t3_rxdata");

        // T6: DATA read accepted in the DONE cycle (acceptance + 17 at DIV=0)
        miso_one = 1'b0;
        push_byte(8'h81, 2, 1'b1);
        bus_req(A_DATA, 4'h1, 32'h81, 32'h0, 1'b0, "t6_wr", t_dummy);
        repeat (14) @(posedge clk);
        rd(A_DATA, 32'hFF, "t6_old_rx");
        rd(A_STATUS, 32'h2, "t6_valid_kept");
        rd(A_DATA, 32'h81, "t6_new_rx");
        rd(A_STATUS, 32'h0, "t6_status");

        repeat (5) @(posedge clk);
        check_val("spi_q_empty", bit_q.size(), 32'h0);
        check_val("bus_q_empty", bus_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
